spi_byte_master: RTL and testbench
==================================

Name: spi_byte_master

Overview:
- 8-bit SPI master shift engine, SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the 16-bit SPI transaction controller.
- Consumes that controller's spi_start / spi_data_in and returns spi_busy / spi_data_out.
- Drives SCLK/MOSI to the pins and samples MISO. CS is owned by the controller, not this block.

Parameters:
- CLK_DIV, 5: clk cycles per SCLK half-period. Legal range 1..255. Default gives 10 MHz SCLK from 100 MHz clk.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- spi_start  input  1  transfer request; only its rising edge is used (the upstream block holds it high for several cycles)
- spi_data_in  input  8  byte to transmit; sampled on the accepting cycle
- miso  input  1  serial data from slave
- spi_busy  output  1  high while a byte is in flight
- spi_data_out  output  8  last received byte; valid from the cycle spi_busy falls until the next completion
- sclk  output  1  SPI clock; idles low
- mosi  output  1  serial data to slave

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - spi_busy=0, spi_data_out=8'h00, sclk=0, mosi=0.
  - state=IDLE, start_q=0, all counters and shift registers 0.
  - Reset mid-transfer abandons the byte immediately. No completion and no spi_data_out update occur.
- Start detection:
  - start_q <= spi_start every cycle, in every state.
  - start_rise = spi_start & ~start_q.
  - A start level held high produces exactly one request.
- States: IDLE, SHIFT.
- IDLE, on start_rise:
  - tx_sr <= spi_data_in, mosi <= spi_data_in[7], spi_busy <= 1.
  - div_cnt <= 0, bit_cnt <= 0, sclk stays 0, then go to SHIFT.
  - spi_busy rises one cycle after the start edge is visible.
- IDLE otherwise: outputs hold; sclk=0; mosi=0.
- SHIFT, dividing:
  - div_cnt increments each cycle.
  - When div_cnt==CLK_DIV-1: div_cnt <= 0 and sclk toggles.
  - Otherwise sclk holds.
- SHIFT, rising toggle (sclk 0->1): rx_sr <= {rx_sr[6:0], miso}. MISO is sampled at that clk edge, unsynchronised; synchronisation is a board-level concern.
- SHIFT, falling toggle (sclk 1->0), bit_cnt<7:
  - tx_sr <= tx_sr<<1, mosi <= tx_sr[6], bit_cnt <= bit_cnt+1.
- SHIFT, falling toggle, bit_cnt==7, all in the same edge:
  - spi_data_out <= rx_sr.
  - spi_busy <= 0, mosi <= 0, go to IDLE.
  - spi_data_out is therefore already valid in the first cycle spi_busy reads 0. The upstream controller latches data on the falling edge of busy.
- Timing:
  - spi_busy is high for exactly 16*CLK_DIV cycles.
  - Exactly 8 SCLK high pulses, each CLK_DIV cycles wide.
  - First SCLK rise occurs CLK_DIV cycles after spi_busy rises.
- start_rise while in SHIFT: ignored, not queued. spi_data_in changes while in SHIFT have no effect.
- start_rise in the same cycle the FSM returns to IDLE: ignored, because the FSM is still in SHIFT that cycle. A new byte needs a fresh rising edge after spi_busy=0.
- CLK_DIV=1: sclk toggles every cycle; the sample/shift rules above are unchanged.
- Widths:
  - div_cnt is 8 bits; bit_cnt is 3 bits.
  - No arithmetic beyond increments; counters never wrap within a transfer.

Test Plan:
- Loopback (miso=mosi), CLK_DIV=5, spi_data_in=8'hA5, spi_start high 10 cycles -> spi_busy high exactly 80 cycles; 8 sclk pulses; mosi bit sequence 1,0,1,0,0,1,0,1 at sclk rises; spi_data_out=8'hA5 when busy falls.
- miso tied 1, spi_data_in=8'h00 -> mosi stays 0 throughout; spi_data_out=8'hFF; spi_start held high 30 cycles still yields exactly one transfer.
- Extra start pulse at cycle 20 of a transfer with spi_data_in=8'h3C -> ignored; transfer completes with original data; no second busy period follows.
- reset_n=0 for one cycle at cycle 40 of a transfer -> next cycle spi_busy=0, sclk=0, mosi=0, spi_data_out=8'h00; a subsequent start runs a clean 80-cycle transfer.
- 16-bit controller model drives bytes 8'h12 then 8'h34 in loopback -> two busy periods of 80 cycles; spi_data_out reads 8'h12 then 8'h34 at the respective busy falling edges.
- CLK_DIV=1, loopback 8'h81 -> spi_busy high 16 cycles; sclk toggles every cycle; spi_data_out=8'h81.

Source files
------------

// File: rtl/spi_byte_master.sv
// SPI mode 0 byte shifter: drives SCLK/MOSI MSB first and gathers MISO into a
// byte. A rising edge on spi_start launches one byte. spi_busy covers the
// whole transfer, and spi_data_out is updated on the same edge that spi_busy
// drops. Chip select is handled by the upstream transaction controller.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start edge; sclk and mosi held low
// SHIFT | byte in flight; sclk toggles every CLK_DIV clk cycles
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_start,
    input  logic [7:0] spi_data_in,
    input  logic       miso,
    output logic       spi_busy,
    output logic [7:0] spi_data_out,
    output logic       sclk,
    output logic       mosi
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    state_t     state_nxt;
    logic       start_q;
    logic       start_rise;
    logic [7:0] div_cnt;
    logic [7:0] div_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_nxt;
    logic [7:0] tx_sr;
    logic [7:0] tx_nxt;
    logic [7:0] rx_sr;
    logic [7:0] rx_nxt;
    logic       sclk_nxt;
    logic       mosi_nxt;
    logic       busy_nxt;
    logic [7:0] dout_nxt;

    // A start level held for many cycles must launch only one byte.
    assign start_rise = spi_start & ~start_q;

    // Register all state; reset abandons any byte in flight without completing it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            div_cnt      <= 8'd0;
            bit_cnt      <= 3'd0;
            tx_sr        <= 8'd0;
            rx_sr        <= 8'd0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            spi_busy     <= 1'b0;
            spi_data_out <= 8'd0;
        end else begin
            state        <= state_nxt;
            start_q      <= spi_start;
            div_cnt      <= div_nxt;
            bit_cnt      <= bit_nxt;
            tx_sr        <= tx_nxt;
            rx_sr        <= rx_nxt;
            sclk         <= sclk_nxt;
            mosi         <= mosi_nxt;
            spi_busy     <= busy_nxt;
            spi_data_out <= dout_nxt;
        end
    end

    // Next-state and datapath: the divider paces sclk toggles; a rising toggle
    // samples MISO, and a falling toggle shifts out the next bit or ends the byte.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        tx_nxt    = tx_sr;
        rx_nxt    = rx_sr;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;
        busy_nxt  = spi_busy;
        dout_nxt  = spi_data_out;

        case (state)
            IDLE: begin
                sclk_nxt = 1'b0;
                mosi_nxt = 1'b0;
                if (start_rise) begin
                    tx_nxt    = spi_data_in;
                    mosi_nxt  = spi_data_in[7];
                    busy_nxt  = 1'b1;
                    div_nxt   = 8'd0;
                    bit_nxt   = 3'd0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt  = 8'd0;
                    sclk_nxt = ~sclk;
                    if (!sclk) begin
                        rx_nxt = {rx_sr[6:0], miso};
                    end else if (bit_cnt != 3'd7) begin
                        tx_nxt   = {tx_sr[6:0], 1'b0};
                        mosi_nxt = tx_sr[6];
                        bit_nxt  = bit_cnt + 3'd1;
                    end else begin
                        // The last bit has been sampled, so the result is
                        // published on the same edge that drops busy.
                        dout_nxt  = rx_sr;
                        busy_nxt  = 1'b0;
                        mosi_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboard bench for spi_byte_master. Instance 0 uses CLK_DIV=5 and
// instance 1 uses CLK_DIV=1. The stimulus pushes the expected result of each
// byte. A negedge monitor follows each instance and scores every busy falling
// edge: received byte, MOSI bits seen at sclk rises, busy length, pulse count
// and sclk high width.
module tb_spi_byte_master;

    localparam int DIV0 = 5;
    localparam int DIV1 = 1;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_w [2];
    logic [7:0] din_w   [2];
    logic       miso_w  [2];
    logic       busy_w  [2];
    logic [7:0] dout_w  [2];
    logic       sclk_w  [2];
    logic       mosi_w  [2];
    logic       loop_en [2];
    logic       miso_fix[2];

    exp_t exp_q [2][$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign miso_w[0] = loop_en[0] ? mosi_w[0] : miso_fix[0];
    assign miso_w[1] = loop_en[1] ? mosi_w[1] : miso_fix[1];

    spi_byte_master #(.CLK_DIV(DIV0)) dut0 (
        .clk(clk), .reset_n(reset_n), .spi_start(start_w[0]), .spi_data_in(din_w[0]),
        .miso(miso_w[0]), .spi_busy(busy_w[0]), .spi_data_out(dout_w[0]),
        .sclk(sclk_w[0]), .mosi(mosi_w[0])
    );

    spi_byte_master #(.CLK_DIV(DIV1)) dut1 (
        .clk(clk), .reset_n(reset_n), .spi_start(start_w[1]), .spi_data_in(din_w[1]),
        .miso(miso_w[1]), .spi_busy(busy_w[1]), .spi_data_out(dout_w[1]),
        .sclk(sclk_w[1]), .mosi(mosi_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int div_of(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    // Launch one byte on instance g and record what its completion must show.
    task automatic start_byte(input int g, input logic [7:0] data, input int hold,
                              input logic [7:0] exp_rx);
        exp_t e;
        @(posedge clk);
        #1;
        start_w[g] = 1'b1;
        din_w[g]   = data;
        e.rx  = exp_rx;
        e.tx  = data;
        e.len = 16 * div_of(g);
        exp_q[g].push_back(e);
        @(posedge clk);
        #1;
        chk($sformatf("busy_rise%0d", g), 32'(busy_w[g]), 32'd1);
        for (int i = 1; i < hold; i++) @(posedge clk);
        #1;
        start_w[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_w[g] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", g), 32'(busy_w[g]), 32'd0);
    endtask

    // Monitor: per-instance transfer tracking sampled on the falling clk edge.
    initial begin
        logic       prev_busy [2];
        logic       prev_sclk [2];
        int         busy_len  [2];
        int         rises     [2];
        int         high_run  [2];
        logic [7:0] tx_seq    [2];
        exp_t       e;
        for (int g = 0; g < 2; g++) begin
            prev_busy[g] = 1'b0;
            prev_sclk[g] = 1'b0;
            busy_len[g]  = 0;
            rises[g]     = 0;
            high_run[g]  = 0;
            tx_seq[g]    = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!reset_n) begin
                    exp_q[g].delete();
                    prev_busy[g] = 1'b0;
                    prev_sclk[g] = 1'b0;
                    high_run[g]  = 0;
                end else begin
                    if (busy_w[g] && !prev_busy[g]) begin
                        busy_len[g] = 0;
                        rises[g]    = 0;
                        tx_seq[g]   = 8'h00;
                    end
                    if (busy_w[g]) busy_len[g]++;
                    if (sclk_w[g] && !prev_sclk[g]) begin
                        rises[g]++;
                        tx_seq[g] = {tx_seq[g][6:0], mosi_w[g]};
                    end
                    if (sclk_w[g]) high_run[g]++;
                    if (!sclk_w[g] && prev_sclk[g]) begin
                        chk($sformatf("sclk_high_width%0d", g), 32'(high_run[g]), 32'(div_of(g)));
                        high_run[g] = 0;
                    end
                    if (!busy_w[g] && prev_busy[g]) begin
                        if (exp_q[g].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_completion%0d: got data %0h, no transfer expected", g, dout_w[g]);
                        end else begin
                            e = exp_q[g].pop_front();
                            chk($sformatf("data_out%0d", g), 32'(dout_w[g]), 32'(e.rx));
                            chk($sformatf("mosi_bits%0d", g), 32'(tx_seq[g]), 32'(e.tx));
                            chk($sformatf("busy_len%0d", g), 32'(busy_len[g]), 32'(e.len));
                            chk($sformatf("sclk_pulses%0d", g), 32'(rises[g]), 32'd8);
                        end
                    end
                    prev_busy[g] = busy_w[g];
                    prev_sclk[g] = sclk_w[g];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            start_w[g]  = 1'b0;
            din_w[g]    = 8'h00;
            loop_en[g]  = 1'b1;
            miso_fix[g] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy_w[0]), 32'd0);
        chk("reset_data", 32'(dout_w[0]), 32'h00);
        chk("reset_sclk", 32'(sclk_w[0]), 32'd0);
        chk("reset_mosi", 32'(mosi_w[0]), 32'd0);

        // Loopback A5, start held 10 cycles.
        start_byte(0, 8'hA5, 10, 8'hA5);
        wait_idle(0);

        // MISO tied high, transmit 00, start held 30 cycles: one transfer only.
        loop_en[0]  = 1'b0;
        miso_fix[0] = 1'b1;
        start_byte(0, 8'h00, 30, 8'hFF);
        wait_idle(0);
        repeat (100) @(negedge clk);
        chk("single_xfer_busy", 32'(busy_w[0]), 32'd0);
        loop_en[0] = 1'b1;

        // Extra start pulse with 3C about 20 cycles into a transfer is ignored.
        start_byte(0, 8'h5A, 2, 8'h5A);
        repeat (18) @(posedge clk);
        #1;
        start_w[0] = 1'b1;
        din_w[0]   = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        wait_idle(0);
        repeat (120) @(negedge clk);
        chk("no_second_busy", 32'(busy_w[0]), 32'd0);

        // One-cycle reset about 40 cycles into a transfer.
        start_byte(0, 8'hC3, 2, 8'hC3);
        repeat (38) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_sclk", 32'(sclk_w[0]), 32'd0);
        chk("abort_mosi", 32'(mosi_w[0]), 32'd0);
        chk("abort_data", 32'(dout_w[0]), 32'h00);
        start_byte(0, 8'h96, 3, 8'h96);
        wait_idle(0);

        // Controller-style pair of bytes for a 16-bit word 0x1234.
        start_byte(0, 8'h12, 4, 8'h12);
        wait_idle(0);
        start_byte(0, 8'h34, 4, 8'h34);
        wait_idle(0);

        // CLK_DIV=1 instance, loopback 81.
        start_byte(1, 8'h81, 3, 8'h81);
        wait_idle(1);

        repeat (10) @(negedge clk);
        chk("queue_empty0", 32'(exp_q[0].size()), 32'd0);
        chk("queue_empty1", 32'(exp_q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
